// File: rtl/delay_var_if.sv
// Streaming port bundle for the variable delay line: master drives data and control,
// slave returns the delayed word, its valid tag and the window-refilled flag.
interface delay_var_if #(
    parameter int N  = 1,
    parameter int SW = 5
);
    logic          ce;
    logic          clr;
    logic [SW-1:0] sel;
    logic [N-1:0]  d;
    logic          d_vld;
    logic [N-1:0]  q;
    logic          q_vld;
    logic          ready;

    modport master (output ce, clr, sel, d, d_vld, input  q, q_vld, ready);
    modport slave  (input  ce, clr, sel, d, d_vld, output q, q_vld, ready);
endinterface

// File: rtl/delay_var.sv
// Clock-enabled variable delay line: taps stage sel_r, gating the valid tag until
// the selected window has been refilled after a delay change, clr or reset.
module delay_var #(
    parameter int N         = 1,
    parameter int MAX_DELAY = 16,
    parameter int SW        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    delay_var_if.slave bus
);
    localparam logic [SW-1:0] MAXD = SW'(MAX_DELAY);

    logic [N-1:0]       s [1:MAX_DELAY];
    logic [MAX_DELAY:1] v;
    logic [SW-1:0]      sel_r;
    logic [SW-1:0]      fcnt;
    logic [SW-1:0]      sel_c;
    logic [N-1:0]       tap_d;
    logic               tap_v;
    logic               ready_c;

    always_comb begin
        sel_c = bus.sel;
        if (bus.sel > MAXD) sel_c = MAXD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= MAX_DELAY; k++) s[k] <= '0;
            v     <= '0;
            sel_r <= '0;
            fcnt  <= '0;
        end else begin
            // Data stages and sel_r follow ce only; clr never touches data.
            if (bus.ce) begin
                s[1] <= bus.d;
                for (int unsigned k = 2; k <= MAX_DELAY; k++) s[k] <= s[k-1];
                sel_r <= sel_c;
            end
            if (bus.clr) begin
                v    <= '0;
                fcnt <= '0;
            end else if (bus.ce) begin
                v[1] <= bus.d_vld;
                for (int unsigned k = 2; k <= MAX_DELAY; k++) v[k] <= v[k-1];
                if (sel_c != sel_r)
                    fcnt <= '0;
                else if (fcnt < MAXD)
                    fcnt <= fcnt + SW'(1);
            end
        end
    end

    always_comb begin
        tap_d = '0;
        tap_v = 1'b0;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
            if (sel_r == SW'(k)) begin
                tap_d = s[k];
                tap_v = v[k];
            end
        end
    end

    always_comb begin
        ready_c   = (fcnt >= sel_r);
        bus.ready = ready_c;
        // sel_r == 0 is a pure combinational bypass of the input.
        if (sel_r == '0) begin
            bus.q     = bus.d;
            bus.q_vld = bus.d_vld;
        end else begin
            bus.q     = tap_d;
            bus.q_vld = tap_v & ready_c;
        end
    end
endmodule

// File: tb/tb_delay_var.sv
// Directed bench for delay_var (N=8, MAX_DELAY=16, SW=5) with hand-derived expectations.
module tb_delay_var;
    logic clk;
    logic rst_n;
    int   cnt;
    int   errs;

    delay_var_if #(.N(8), .SW(5)) bus ();

    delay_var #(.N(8), .MAX_DELAY(16), .SW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cnt++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic clr, input logic [4:0] sel,
                         input logic [7:0] d, input logic d_vld);
        bus.ce    = ce;
        bus.clr   = clr;
        bus.sel   = sel;
        bus.d     = d;
        bus.d_vld = d_vld;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] q, input logic qv, input logic rdy);
        chk({tag, ".q"},     32'(bus.q),     32'(q));
        chk({tag, ".q_vld"}, 32'(bus.q_vld), 32'(qv));
        chk({tag, ".ready"}, 32'(bus.ready), 32'(rdy));
    endtask

    task automatic chk_gate(input string tag, input logic qv, input logic rdy);
        chk({tag, ".q_vld"}, 32'(bus.q_vld), 32'(qv));
        chk({tag, ".ready"}, 32'(bus.ready), 32'(rdy));
    endtask

    initial begin
        int kk;
        cnt  = 0;
        errs = 0;

        // Reset: bypass passthrough while held and after release.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 8'h5A, 1'b1);
        #1;
        chk_out("rst_bypass", 8'h5A, 1'b1, 1'b1);
        #11;
        rst_n = 1'b1;
        #1;
        bus.d_vld = 1'b0;
        #1;
        chk_out("post_rst", 8'h5A, 1'b0, 1'b1);

        // Fixed delay 5: load edge carries no valid word, then 0x01, 0x02, ...
        drive(1'b1, 1'b0, 5'd5, 8'h00, 1'b0);
        step();
        chk_gate("fix_load", 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            bus.d = 8'(i);
            bus.d_vld = 1'b1;
            step();
            if (i < 5) chk_gate($sformatf("fix_fill%0d", i), 1'b0, 1'b0);
            else       chk_out($sformatf("fix_run%0d", i), 8'(i - 4), 1'b1, 1'b1);
        end

        // ce gapping at delay 3: outputs only move on ce=1 edges.
        drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
        step();
        kk = 0;
        for (int c = 0; c < 12; c++) begin
            if (c % 2 == 0) begin
                drive(1'b1, 1'b0, 5'd3, 8'hA0 + 8'(kk), 1'b1);
                kk++;
            end else begin
                drive(1'b0, 1'b0, 5'd3, 8'hEE, 1'b1);
            end
            step();
            if (kk < 3) chk_gate($sformatf("gap_fill%0d", c), 1'b0, 1'b0);
            else        chk_out($sformatf("gap_run%0d", c), 8'hA0 + 8'(kk - 3), 1'b1, 1'b1);
        end

        // Stream at delay 8, then shrink to 2.
        drive(1'b1, 1'b0, 5'd8, 8'h00, 1'b0);
        step();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b0, 5'd8, 8'h30 + 8'(k - 1), 1'b1);
            step();
            if (k < 8) chk_gate($sformatf("s8_fill%0d", k), 1'b0, 1'b0);
            else       chk_out($sformatf("s8_run%0d", k), 8'h30 + 8'(k - 8), 1'b1, 1'b1);
        end
        drive(1'b1, 1'b0, 5'd2, 8'h3A, 1'b1);
        step();
        chk_out("shrink_edge", 8'h39, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 5'd2, 8'h3A + 8'(k), 1'b1);
            step();
            if (k < 2) chk_out($sformatf("shrink_fill%0d", k), 8'h3A, 1'b0, 1'b0);
            else       chk_out($sformatf("shrink_run%0d", k), 8'h3A + 8'(k - 1), 1'b1, 1'b1);
        end

        // Delay 4, then a one-edge clr with ce=0.
        drive(1'b1, 1'b0, 5'd4, 8'h50, 1'b1);
        step();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 5'd4, 8'h50 + 8'(k), 1'b1);
            step();
            if (k < 4) chk_gate($sformatf("s4_fill%0d", k), 1'b0, 1'b0);
            else       chk_out($sformatf("s4_run%0d", k), 8'h50 + 8'(k - 3), 1'b1, 1'b1);
        end
        drive(1'b0, 1'b1, 5'd4, 8'hEE, 1'b1);
        step();
        chk_out("clr_edge", 8'h53, 1'b0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            drive(1'b1, 1'b0, 5'd4, 8'h56 + 8'(j), 1'b1);
            step();
            if (j < 4) chk_out($sformatf("clr_fill%0d", j), 8'h53 + 8'(j), 1'b0, 1'b0);
            else       chk_out($sformatf("clr_run%0d", j), 8'h53 + 8'(j), 1'b1, 1'b1);
        end

        // Clamp: sel=31 acts as 16.
        drive(1'b1, 1'b0, 5'd31, 8'h70, 1'b0);
        step();
        for (int k = 1; k <= 18; k++) begin
            drive(1'b1, 1'b0, 5'd31, 8'h70 + 8'(k), 1'b1);
            step();
            if (k < 16) chk_gate($sformatf("clamp_fill%0d", k), 1'b0, 1'b0);
            else        chk_out($sformatf("clamp_run%0d", k), 8'h70 + 8'(k - 15), 1'b1, 1'b1);
        end

        // Bypass: sel=0 follows d combinationally.
        drive(1'b1, 1'b0, 5'd0, 8'h99, 1'b1);
        step();
        chk_out("byp_edge", 8'h99, 1'b1, 1'b1);
        bus.d = 8'h9A;
        #1;
        chk_out("byp_comb", 8'h9A, 1'b1, 1'b1);
        bus.d_vld = 1'b0;
        #1;
        chk_out("byp_novld", 8'h9A, 1'b0, 1'b1);

        // Async reset mid-stream at delay 3.
        drive(1'b1, 1'b0, 5'd3, 8'h80, 1'b1);
        step();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b0, 5'd3, 8'h80 + 8'(k), 1'b1);
            step();
        end
        chk_out("ar_pre", 8'h83, 1'b1, 1'b1);
        bus.d = 8'h86;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("ar_bypass", 8'h86, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
        #1;
        chk_out("ar_zero", 8'h00, 1'b0, 1'b1);
        step();
        bus.ce = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk_out("ar_release", 8'h00, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
        step();
        chk_out("ar_stages_cleared", 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
        $finish;
    end
endmodule

// File: doc/delay_var.md
DELAY_VAR -- requirements
Module: delay_var

Interface
REQ-001 Parameter N, default 1: data width in bits, N >= 1.
REQ-002 Parameter MAX_DELAY, default 16: number of physical delay stages, MAX_DELAY >= 1.
REQ-003 Parameter SW, default 5: width of sel; integrator guarantees 2^SW > MAX_DELAY.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 ce  in  1  clock enable; the pipeline advances only when 1.
REQ-007 clr  in  1  synchronous flush of valid tags and fill state.
REQ-008 sel  in  SW  requested delay in ce-strobed cycles, 0..MAX_DELAY.
REQ-009 d  in  N  input data.
REQ-010 d_vld  in  1  input valid tag.
REQ-011 q  out  N  delayed data.
REQ-012 q_vld  out  1  delayed valid tag, gated by ready.
REQ-013 ready  out  1  1 when the active delay window is fully refilled.

Function
REQ-014 Storage SHALL be data stages s[1..MAX_DELAY] (N bits each) plus valid stages v[1..MAX_DELAY] (1 bit each).
REQ-015 Each stage pair SHALL shift on a ce=1 edge: s[1]<=d, v[1]<=d_vld, s[k]<=s[k-1], v[k]<=v[k-1]; on ce=0 all stages hold.
REQ-016 Register sel_r (active delay) and counter fcnt (0..MAX_DELAY, saturating) SHALL update only on ce=1 edges, except as stated in REQ-020.
REQ-017 sel_c SHALL be sel clamped to MAX_DELAY when sel > MAX_DELAY.
REQ-018 On a ce=1 edge with clr=0 and sel_c != sel_r: sel_r<=sel_c, fcnt<=0; the data and valid stages still shift.
REQ-019 On a ce=1 edge with clr=0 and sel_c == sel_r: fcnt<=min(fcnt+1, MAX_DELAY).
REQ-020 On any edge with clr=1, regardless of ce: all v[k]<=0 and fcnt<=0; sel_r loads sel_c if ce=1; clr has priority over REQ-018 and REQ-019.
REQ-021 clr SHALL NOT clear the data stages; with ce=1 they shift per REQ-015.
REQ-022 ready SHALL be combinational (fcnt >= sel_r).
REQ-023 With sel_r=0 (bypass): q=d, q_vld=d_vld, ready=1, all combinational with zero latency.
REQ-024 With sel_r=m>0: q=s[m] and q_vld=v[m] & ready.
REQ-025 Latency SHALL therefore be exactly m ce-strobed cycles; ce=0 cycles add no latency and lose no data.
REQ-026 After a delay change or clr, ready SHALL rise after exactly sel_r further ce=1 edges.
REQ-027 q_vld SHALL stay 0 while ready=0, even if a stale v[m] is 1.
REQ-028 A word entered on the change edge SHALL NOT be guaranteed valid at the output; the first guaranteed word is the one entered on the next ce=1 edge.
REQ-029 Shrinking the delay SHALL discard the words in stages beyond the new tap; no output pulse is produced for them.
REQ-030 Growing the delay SHALL suppress output until refill, so no word is emitted twice.

Reset
REQ-031 While rst_n=0, all s[k] SHALL be 0, all v[k] 0, sel_r 0 and fcnt 0.
REQ-032 Immediately after reset the block SHALL be in bypass, so q=d, q_vld=d_vld and ready=1 until the first ce=1 edge with sel_c != 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight data and tags at once, without waiting for a clock edge.

Verification
REQ-034 Fixed delay: N=8, MAX_DELAY=16, sel=5, ce=1, d incrementing from 0x01 with d_vld=1 -> ready rises on the 5th edge after sel load; q=0x01, q_vld=1 on that cycle, then q increments each cycle.
REQ-035 ce gapping: sel=3, ce toggling 1/0, d=0xA0, 0xA1, ... on ce=1 cycles -> q sequence is unchanged with latency of 3 ce edges; q and q_vld hold during ce=0 cycles.
REQ-036 Delay change: streaming at sel=8, then sel=2 -> ready=0 and q_vld=0 for 2 ce edges, then the sequence resumes from the word entered after the change; words in stages 3..8 never appear.
REQ-037 clr mid-stream: sel=4, clr asserted for 1 edge with ce=0 -> q_vld=0 for the next 4 ce edges while q data continue shifting; q_vld=1 thereafter.
REQ-038 Clamp and bypass: sel=31 with MAX_DELAY=16 -> latency 16; sel=0 -> q follows d in the same cycle with ready=1.
REQ-039 Async reset: rst_n pulsed low between edges while streaming -> q=0, q_vld=0 (bypass passthrough of d, d_vld when sel_r=0) immediately; ready=1.
